// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator control slice.
package elevator_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    CMP,
    UP,
    DOWN,
    STEP,
    DOOR
  } ctrl_state_t;

  localparam int unsigned FLOOR_W = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_controller_if.sv
// Request handshake and datapath strobe bundle between the controller and its neighbours.
interface elevator_controller_if;
  import elevator_pkg::*;

  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_ready;
  logic               req_err;
  logic               dest_less;
  logic               dest_more;
  logic [FLOOR_W-1:0] X;
  logic               dest_ld;
  logic               dest_clr;
  logic               floor_ld;
  logic               floor_clr;
  logic               mux_sig;
  logic               dir;
  logic               run;
  logic               hold2;
  logic               busy;

  modport master (
    input  req_valid, req_floor, dest_less, dest_more,
    output req_ready, req_err, X, dest_ld, dest_clr, floor_ld, floor_clr,
           mux_sig, dir, run, hold2, busy
  );

  modport slave (
    output req_valid, req_floor, dest_less, dest_more,
    input  req_ready, req_err, X, dest_ld, dest_clr, floor_ld, floor_clr,
           mux_sig, dir, run, hold2, busy
  );

endinterface

// File: rtl/elevator_controller_timer.sv
// Saturating up-counter with clear, load and terminal-count compare, shared by travel and door phases.
module ctrl_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/elevator_controller.sv
// Elevator control FSM: latches one request, steps the cabin floor by floor, then holds the door.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 100000000,
  parameter int unsigned DOOR_CYCLES   = 200000000,
  parameter int unsigned MAX_FLOOR     = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  elevator_controller_if.master ctrl
);

  localparam int unsigned MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0]    TRAVEL_TC = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]    DOOR_TC   = TW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0] MAX_F     = MAX_FLOOR[FLOOR_W:0];

  ctrl_state_t        state_q, state_d;
  logic [FLOOR_W-1:0] x_q, x_d;
  logic               dir_q, dir_d;
  logic               req_err_q, req_err_d;

  logic               moving;
  logic               in_range;
  logic               step_ld;
  logic               tmr_clr;
  logic               tmr_en;
  logic               tmr_tc;
  logic [TW-1:0]      tmr_tc_val;

  assign moving   = (state_q == UP) || (state_q == DOWN);
  assign in_range = ({1'b0, ctrl.req_floor} <= MAX_F);

  assign tmr_clr    = (state_q == CMP);
  assign tmr_en     = moving || (state_q == DOOR);
  assign tmr_tc_val = moving ? TRAVEL_TC : DOOR_TC;

  ctrl_timer #(
    .W (TW)
  ) u_timer (
    .clk_i    (CLK),
    .rst_n_i  (RST_N),
    .clr_i    (tmr_clr),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .en_i     (tmr_en),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    dir_d     = dir_q;
    req_err_d = 1'b0;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (ctrl.req_valid) begin
          if (in_range) begin
            x_d     = ctrl.req_floor;
            state_d = LOAD;
          end else begin
            req_err_d = 1'b1;
          end
        end
      end
      LOAD: state_d = CMP;
      // Both flags high is treated as arrival so the cabin never moves on a bad compare.
      CMP: begin
        if (ctrl.dest_more && !ctrl.dest_less) begin
          dir_d   = DIR_UP;
          state_d = UP;
        end else if (ctrl.dest_less && !ctrl.dest_more) begin
          dir_d   = DIR_DOWN;
          state_d = DOWN;
        end else begin
          state_d = DOOR;
        end
      end
      UP, DOWN: begin
        if (tmr_tc) begin
          state_d = STEP;
        end
      end
      STEP: state_d = CMP;
      DOOR: begin
        if (tmr_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= INIT;
      x_q       <= '0;
      dir_q     <= DIR_DOWN;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      dir_q     <= dir_d;
      req_err_q <= req_err_d;
    end
  end

  assign step_ld = moving && tmr_tc;

  // INIT is the reset state; gating with RST_N keeps the clears low while reset is held.
  assign ctrl.dest_clr  = (state_q == INIT) && RST_N;
  assign ctrl.floor_clr = (state_q == INIT) && RST_N;

  assign ctrl.req_ready = (state_q == IDLE);
  assign ctrl.req_err   = req_err_q;
  assign ctrl.X         = x_q;
  assign ctrl.dest_ld   = (state_q == LOAD);
  assign ctrl.floor_ld  = step_ld;
  assign ctrl.mux_sig   = step_ld ? dir_q : 1'b0;
  assign ctrl.dir       = dir_q;
  assign ctrl.run       = moving || (state_q == STEP);
  assign ctrl.hold2     = (state_q == DOOR);
  assign ctrl.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_controller.sv
// Randomized bench: per-request expectations derived from floor distance and cycle parameters.
module tb_elevator_controller;
  import elevator_pkg::*;

  localparam int unsigned T  = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned MF = 5;
  localparam int unsigned CYC_LIMIT = 400;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [2:0] mdl_floor = 3'd0;
  logic [2:0] mdl_x     = 3'd0;

  // Datapath model: registers without reset, start with junk so the clears are observable.
  logic [2:0] dp_dest  = 3'd1;
  logic [2:0] dp_floor = 3'd6;

  elevator_controller_if bus();

  elevator_controller #(
    .TRAVEL_CYCLES (T),
    .DOOR_CYCLES   (D),
    .MAX_FLOOR     (MF)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .ctrl  (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.dest_clr) dp_dest <= 3'd0;
    else if (bus.dest_ld) dp_dest <= bus.X;
    if (bus.floor_clr) dp_floor <= 3'd0;
    else if (bus.floor_ld) dp_floor <= bus.mux_sig ? dp_floor + 3'd1 : dp_floor - 3'd1;
  end

  assign bus.dest_less = (dp_dest < dp_floor);
  assign bus.dest_more = (dp_dest > dp_floor);

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic request(input logic [2:0] f);
    int unsigned n, cyc, n_ld, n_hold, n_run, n_dld, last_ld;
    int unsigned bad_mux, bad_dir, bad_gap, bad_x, bad_misc;
    logic up;
    check("idle_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_floor = f;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    if (f > MF) begin
      check("err_pulse", bus.req_err, 1);
      check("err_busy", bus.busy, 0);
      check("err_x", bus.X, mdl_x);
      @(negedge CLK);
      check("err_width", bus.req_err, 0);
      check("err_ready", bus.req_ready, 1);
      return;
    end
    up = (f > mdl_floor);
    n  = up ? f - mdl_floor : mdl_floor - f;
    cyc = 0; n_ld = 0; n_hold = 0; n_run = 0; n_dld = 0; last_ld = 0;
    bad_mux = 0; bad_dir = 0; bad_gap = 0; bad_x = 0; bad_misc = 0;
    while (bus.busy && cyc < CYC_LIMIT) begin
      if (bus.floor_ld) begin
        n_ld++;
        if (bus.mux_sig !== up) bad_mux++;
        if (n_ld > 1 && (cyc - last_ld) != T + 2) bad_gap++;
        last_ld = cyc;
      end else if (bus.mux_sig) begin
        bad_mux++;
      end
      if (bus.run) begin
        n_run++;
        if (bus.dir !== up) bad_dir++;
      end
      if (bus.hold2) n_hold++;
      if (bus.dest_ld) n_dld++;
      if (bus.X !== f) bad_x++;
      if (bus.req_err || bus.req_ready || bus.dest_clr || bus.floor_clr || dp_floor > MF) bad_misc++;
      cyc++;
      bus.req_valid = ($urandom_range(0, 3) == 0);
      bus.req_floor = 3'($urandom_range(0, 7));
      @(negedge CLK);
    end
    bus.req_valid = 1'b0;
    check("no_timeout", (cyc < CYC_LIMIT), 1);
    check("busy_cycles", cyc, 2 + n * (T + 2) + D);
    check("floor_ld_cnt", n_ld, n);
    check("run_cycles", n_run, n * (T + 1));
    check("hold2_cycles", n_hold, D);
    check("dest_ld_cnt", n_dld, 1);
    check("mux_sig", bad_mux, 0);
    check("dir", bad_dir, 0);
    check("ld_spacing", bad_gap, 0);
    check("x_stable", bad_x, 0);
    check("busy_misc", bad_misc, 0);
    check("final_floor", dp_floor, f);
    check("final_dest", dp_dest, f);
    check("idle_no_err", bus.req_err, 0);
    mdl_floor = f;
    mdl_x     = f;
  endtask

  initial begin
    logic [2:0] target;
    bus.req_valid = 1'b0;
    bus.req_floor = 3'd0;
    repeat (2) @(negedge CLK);
    check("rst_run", bus.run, 0);
    check("rst_dest_clr", bus.dest_clr, 0);
    check("rst_floor_clr", bus.floor_clr, 0);
    check("rst_dest_ld", bus.dest_ld, 0);
    check("rst_floor_ld", bus.floor_ld, 0);
    check("rst_hold2", bus.hold2, 0);
    check("rst_req_err", bus.req_err, 0);
    check("rst_x", bus.X, 0);
    check("rst_dir", bus.dir, 0);
    check("rst_mux", bus.mux_sig, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_busy", bus.busy, 1);

    RST_N = 1'b1;
    #1;
    check("init_dest_clr", bus.dest_clr, 1);
    check("init_floor_clr", bus.floor_clr, 1);
    check("init_ready", bus.req_ready, 0);
    @(negedge CLK);
    check("idle_dest_clr", bus.dest_clr, 0);
    check("idle_floor_clr", bus.floor_clr, 0);
    check("idle_ready0", bus.req_ready, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_run", bus.run, 0);
    check("idle_hold2", bus.hold2, 0);
    check("idle_dp_floor", dp_floor, 0);
    check("idle_dp_dest", dp_dest, 0);

    request(3'd3);
    request(3'd1);
    request(3'd1);
    request(3'd7);
    request(3'd6);
    request(3'd5);
    request(3'd0);

    target = (mdl_floor < 3'd3) ? 3'd5 : 3'd0;
    bus.req_valid = 1'b1;
    bus.req_floor = target;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_run", bus.run, 1);
    #2 RST_N = 1'b0;
    #1;
    check("async_run", bus.run, 0);
    check("async_floor_ld", bus.floor_ld, 0);
    check("async_x", bus.X, 0);
    check("async_dir", bus.dir, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("reinit_dest_clr", bus.dest_clr, 1);
    check("reinit_floor_clr", bus.floor_clr, 1);
    @(negedge CLK);
    check("reinit_clr_done", bus.floor_clr, 0);
    check("reinit_ready", bus.req_ready, 1);
    check("reinit_floor", dp_floor, 0);
    mdl_floor = 3'd0;
    mdl_x     = 3'd0;
    request(3'd2);

    for (int i = 0; i < 20; i++) begin
      request(3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
